// File: rtl/lsu_split_sequencer.sv
// Turns one LSU access into one or two word-aligned OBI transactions and merges the responses.
// Accepts only in IDLE; OBI request fields stay frozen until granted; one resp_valid_o pulse per access.
module lsu_split_sequencer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic              req_we_i,
    input  logic [1:0]        req_size_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              resp_valid_o,
    output logic [DATA_W-1:0] resp_rdata_o,
    output logic              resp_err_o,
    output logic              resp_split_o,
    output logic              obi_req_o,
    input  logic              obi_gnt_i,
    output logic [ADDR_W-1:0] obi_addr_o,
    output logic              obi_we_o,
    output logic [3:0]        obi_be_o,
    output logic [DATA_W-1:0] obi_wdata_o,
    input  logic              obi_rvalid_i,
    input  logic [DATA_W-1:0] obi_rdata_i,
    input  logic              obi_err_i
);
    typedef enum logic [2:0] {S_IDLE, S_ADDR1, S_ADDR2, S_WAIT, S_RESP} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic                we_q;
    logic [1:0]          size_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                split_q;
    logic [1:0]          cnt_q, cnt_d;
    logic [1:0]          issued_q;
    logic                rcv_q;
    logic                err_q;
    logic [DATA_W-1:0]   rdata1_q, rdata2_q;

    logic                accept, gnt_fire, rv_fire, split_in;
    logic [3:0]          nb_in;
    logic [1:0]          off;
    logic [3:0]          mask4;
    logic [7:0]          be_sh;
    logic [2*DATA_W-1:0] wd_sh, rd_sh;
    logic [DATA_W-1:0]   byte_mask;
    logic [ADDR_W-1:0]   base_addr;

    assign accept   = req_valid_i && req_ready_o;
    assign gnt_fire = obi_req_o && obi_gnt_i;
    // A response with nothing outstanding is a bus protocol error and is dropped.
    assign rv_fire  = obi_rvalid_i && (cnt_q != 2'd0);
    assign cnt_d    = cnt_q + 2'(gnt_fire) - 2'(rv_fire);

    assign nb_in    = (req_size_i == 2'd0) ? 4'd1 : (req_size_i == 2'd1) ? 4'd2 : 4'd4;
    assign split_in = ({2'b00, req_addr_i[1:0]} + nb_in) > 4'd4;

    assign off       = addr_q[1:0];
    assign mask4     = (size_q == 2'd0) ? 4'b0001 : (size_q == 2'd1) ? 4'b0011 : 4'b1111;
    assign be_sh     = {4'b0000, mask4} << off;
    assign wd_sh     = {{DATA_W{1'b0}}, wdata_q} << {off, 3'b000};
    assign rd_sh     = {rdata2_q, rdata1_q} >> {off, 3'b000};
    assign byte_mask = (size_q == 2'd0) ? DATA_W'(32'h0000_00FF) :
                       (size_q == 2'd1) ? DATA_W'(32'h0000_FFFF) : {DATA_W{1'b1}};
    assign base_addr = {addr_q[ADDR_W-1:2], 2'b00};

    assign resp_rdata_o = we_q ? '0 : (rd_sh[DATA_W-1:0] & byte_mask);
    assign resp_err_o   = err_q;
    assign resp_split_o = split_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            addr_q   <= '0;
            we_q     <= 1'b0;
            size_q   <= 2'd0;
            wdata_q  <= '0;
            split_q  <= 1'b0;
            cnt_q    <= 2'd0;
            issued_q <= 2'd0;
            rcv_q    <= 1'b0;
            err_q    <= 1'b0;
            rdata1_q <= '0;
            rdata2_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (accept) begin
                addr_q   <= req_addr_i;
                we_q     <= req_we_i;
                size_q   <= req_size_i;
                wdata_q  <= req_wdata_i;
                split_q  <= split_in;
                issued_q <= 2'd0;
                rcv_q    <= 1'b0;
                err_q    <= 1'b0;
                rdata1_q <= '0;
                rdata2_q <= '0;
            end else begin
                if (gnt_fire) begin
                    issued_q <= issued_q + 2'd1;
                end
                // OBI returns in order, so the first response always belongs to the low word.
                if (rv_fire) begin
                    err_q <= err_q | obi_err_i;
                    rcv_q <= 1'b1;
                    if (!rcv_q) begin
                        rdata1_q <= obi_rdata_i;
                    end else begin
                        rdata2_q <= obi_rdata_i;
                    end
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_valid_i) state_d = S_ADDR1;
            S_ADDR1: if (obi_gnt_i) state_d = split_q ? S_ADDR2 : S_WAIT;
            S_ADDR2: if (obi_gnt_i) state_d = S_WAIT;
            S_WAIT:  if (cnt_d == 2'd0 && issued_q == (split_q ? 2'd2 : 2'd1)) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        obi_req_o    = 1'b0;
        obi_addr_o   = '0;
        obi_we_o     = 1'b0;
        obi_be_o     = 4'b0000;
        obi_wdata_o  = '0;
        case (state_q)
            S_IDLE: req_ready_o = 1'b1;
            S_ADDR1: begin
                obi_req_o   = 1'b1;
                obi_addr_o  = base_addr;
                obi_we_o    = we_q;
                obi_be_o    = be_sh[3:0];
                obi_wdata_o = wd_sh[DATA_W-1:0];
            end
            S_ADDR2: begin
                obi_req_o   = 1'b1;
                obi_addr_o  = base_addr + ADDR_W'(4);
                obi_we_o    = we_q;
                obi_be_o    = be_sh[7:4];
                obi_wdata_o = wd_sh[2*DATA_W-1:DATA_W];
            end
            S_RESP: resp_valid_o = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_lsu_split_sequencer.sv
module tb_lsu_split_sequencer;
    logic        clk_i;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_addr_i;
    logic        req_we_i;
    logic [1:0]  req_size_i;
    logic [31:0] req_wdata_i;
    logic        resp_valid_o;
    logic [31:0] resp_rdata_o;
    logic        resp_err_o;
    logic        resp_split_o;
    logic        obi_req_o;
    logic        obi_gnt_i;
    logic [31:0] obi_addr_o;
    logic        obi_we_o;
    logic [3:0]  obi_be_o;
    logic [31:0] obi_wdata_o;
    logic        obi_rvalid_i;
    logic [31:0] obi_rdata_i;
    logic        obi_err_i;

    lsu_split_sequencer #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
        .req_we_i(req_we_i), .req_size_i(req_size_i), .req_wdata_i(req_wdata_i),
        .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
        .resp_split_o(resp_split_o), .obi_req_o(obi_req_o), .obi_gnt_i(obi_gnt_i),
        .obi_addr_o(obi_addr_o), .obi_we_o(obi_we_o), .obi_be_o(obi_be_o),
        .obi_wdata_o(obi_wdata_o), .obi_rvalid_i(obi_rvalid_i), .obi_rdata_i(obi_rdata_i),
        .obi_err_i(obi_err_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // Bus behaviour for the next access: grant waits, response delays, returned data/errors.
    int          g_gw[2];
    int          g_rvd[2];
    logic [31:0] g_rd[2];
    logic        g_er[2];

    // What the bench observed during the last access.
    int          n_tx, n_resp, resp_c, last_rv;
    logic [31:0] tx_addr[2];
    logic [31:0] tx_wd[2];
    logic [3:0]  tx_be[2];
    logic        tx_we[2];
    logic [31:0] r_rdata;
    logic        r_err, r_split, unstable;

    task automatic set_bus(input int gw0, input int gw1, input logic [31:0] rd0, input logic [31:0] rd1,
                           input logic e0, input logic e1);
        g_gw[0] = gw0; g_gw[1] = gw1; g_rvd[0] = 0; g_rvd[1] = 0;
        g_rd[0] = rd0; g_rd[1] = rd1; g_er[0] = e0; g_er[1] = e1;
    endtask

    // Reference: place each byte of the access into a two-word window starting at the aligned base.
    task automatic model(input logic [31:0] a, input logic [1:0] sz, input logic we, input logic [31:0] wd,
                         input logic [31:0] r1, input logic [31:0] r2,
                         output logic sp, output logic [3:0] be0, output logic [3:0] be1,
                         output logic [31:0] w0, output logic [31:0] w1, output logic [31:0] rd);
        int nb, off, pos;
        nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        off = int'(a[1:0]);
        be0 = 4'h0; be1 = 4'h0; w0 = 32'h0; w1 = 32'h0; rd = 32'h0;
        for (int i = 0; i < 4; i++) begin
            pos = off + i;
            if (pos < 4) w0[pos*8 +: 8] = wd[i*8 +: 8];
            else         w1[(pos-4)*8 +: 8] = wd[i*8 +: 8];
        end
        for (int i = 0; i < nb; i++) begin
            pos = off + i;
            if (pos < 4) begin
                be0[pos] = 1'b1;
                rd[i*8 +: 8] = r1[pos*8 +: 8];
            end else begin
                be1[pos-4] = 1'b1;
                rd[i*8 +: 8] = r2[(pos-4)*8 +: 8];
            end
        end
        sp = (off + nb > 4);
        if (we) rd = 32'h0;
    endtask

    // Drives one access from a negedge and plays the OBI slave; returns at a negedge with inputs idle.
    task automatic run_access(input logic [31:0] a, input logic [1:0] sz, input logic we, input logic [31:0] wd);
        int due[$];
        int req_wait, nrv, last_due, idx, d;
        logic held;
        logic [68:0] hfields;
        n_tx = 0; n_resp = 0; resp_c = -100; last_rv = -1; unstable = 1'b0;
        nrv = 0; req_wait = 0; last_due = -1; held = 1'b0; hfields = '0;
        for (int c = 0; c < 60; c++) begin
            req_valid_i = (c == 0); req_addr_i = a; req_size_i = sz; req_we_i = we; req_wdata_i = wd;
            obi_gnt_i = 1'b0; obi_rvalid_i = 1'b0; obi_err_i = 1'b0; obi_rdata_i = $urandom;
            if (resp_valid_o) begin
                n_resp++; resp_c = c; r_rdata = resp_rdata_o; r_err = resp_err_o; r_split = resp_split_o;
            end
            if (obi_req_o) begin
                if (held && hfields !== {obi_addr_o, obi_be_o, obi_wdata_o, obi_we_o}) unstable = 1'b1;
                held = 1'b1; hfields = {obi_addr_o, obi_be_o, obi_wdata_o, obi_we_o};
                idx = (n_tx < 2) ? n_tx : 1;
                if (req_wait >= g_gw[idx]) begin
                    obi_gnt_i = 1'b1;
                    if (n_tx < 2) begin
                        tx_addr[n_tx] = obi_addr_o; tx_be[n_tx] = obi_be_o;
                        tx_wd[n_tx] = obi_wdata_o; tx_we[n_tx] = obi_we_o;
                    end
                    n_tx++; held = 1'b0; req_wait = 0;
                    d = c + 1 + g_rvd[idx];
                    if (d <= last_due) d = last_due + 1;
                    last_due = d; due.push_back(d);
                end else begin
                    req_wait++;
                end
            end
            if (due.size() > 0 && due[0] == c) begin
                void'(due.pop_front());
                idx = (nrv < 2) ? nrv : 1;
                obi_rvalid_i = 1'b1; obi_rdata_i = g_rd[idx]; obi_err_i = g_er[idx];
                nrv++; last_rv = c;
            end
            @(negedge clk_i);
            if (n_resp > 0 && c >= resp_c + 3) break;
        end
        req_valid_i = 1'b0; obi_gnt_i = 1'b0; obi_rvalid_i = 1'b0; obi_err_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        total++; if ({req_ready_o, obi_req_o, resp_valid_o, resp_err_o, resp_split_o} !== 5'b10000) begin
            bad++; $display("FAIL rst_ctrl got=%b exp=10000", {req_ready_o, obi_req_o, resp_valid_o, resp_err_o, resp_split_o}); end
        total++; if (resp_rdata_o !== 32'h0) begin
            bad++; $display("FAIL rst_rdata got=%h exp=0", resp_rdata_o); end
        total++; if ({obi_addr_o, obi_be_o, obi_wdata_o, obi_we_o} !== 69'h0) begin
            bad++; $display("FAIL rst_obi got=%h/%b/%h/%b exp=0", obi_addr_o, obi_be_o, obi_wdata_o, obi_we_o); end
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_aligned_load();
        set_bus(0, 0, 32'h1234_5678, 32'h0, 1'b0, 1'b0);
        run_access(32'h1000, 2'd2, 1'b0, $urandom);
        total++; if (n_tx !== 1) begin bad++; $display("FAIL al_ntx got=%0d exp=1", n_tx); end
        total++; if ({tx_addr[0], tx_be[0], tx_we[0]} !== {32'h1000, 4'b1111, 1'b0}) begin
            bad++; $display("FAIL al_txn got=%h/%b/%b exp=1000/1111/0", tx_addr[0], tx_be[0], tx_we[0]); end
        total++; if ({r_rdata, r_split, r_err} !== {32'h1234_5678, 2'b00}) begin
            bad++; $display("FAIL al_resp got=%h/%b/%b exp=12345678/0/0", r_rdata, r_split, r_err); end
        total++; if (resp_c !== 3 || n_resp !== 1) begin
            bad++; $display("FAIL al_timing got=cyc%0d n%0d exp=cyc3 n1", resp_c, n_resp); end
    endtask

    task automatic test_split_store();
        set_bus(0, 0, $urandom, $urandom, 1'b0, 1'b0);
        run_access(32'h1002, 2'd2, 1'b1, 32'hAABB_CCDD);
        total++; if (n_tx !== 2) begin bad++; $display("FAIL ss_ntx got=%0d exp=2", n_tx); end
        total++; if ({tx_addr[0], tx_be[0], tx_wd[0], tx_we[0]} !== {32'h1000, 4'b1100, 32'hCCDD_0000, 1'b1}) begin
            bad++; $display("FAIL ss_txn1 got=%h/%b/%h/%b exp=1000/1100/ccdd0000/1", tx_addr[0], tx_be[0], tx_wd[0], tx_we[0]); end
        total++; if ({tx_addr[1], tx_be[1], tx_wd[1], tx_we[1]} !== {32'h1004, 4'b0011, 32'h0000_AABB, 1'b1}) begin
            bad++; $display("FAIL ss_txn2 got=%h/%b/%h/%b exp=1004/0011/0000aabb/1", tx_addr[1], tx_be[1], tx_wd[1], tx_we[1]); end
        total++; if ({r_split, r_rdata} !== {1'b1, 32'h0}) begin
            bad++; $display("FAIL ss_resp got=split%b rdata%h exp=split1 rdata0", r_split, r_rdata); end
        total++; if (resp_c !== 4) begin bad++; $display("FAIL ss_timing got=%0d exp=4", resp_c); end
    endtask

    task automatic test_split_load_half();
        set_bus(0, 0, 32'h4400_0000, 32'h0000_0055, 1'b0, 1'b0);
        run_access(32'h1003, 2'd1, 1'b0, $urandom);
        total++; if ({tx_be[0], tx_be[1]} !== 8'b1000_0001) begin
            bad++; $display("FAIL slh_be got=%b/%b exp=1000/0001", tx_be[0], tx_be[1]); end
        total++; if (r_rdata !== 32'h0000_5544) begin
            bad++; $display("FAIL slh_rdata got=%h exp=00005544", r_rdata); end
    endtask

    task automatic test_gnt_delay();
        logic sp; logic [3:0] b0, b1; logic [31:0] w0, w1, rd;
        set_bus(0, 3, $urandom, $urandom, 1'b0, 1'b0);
        model(32'h2001, 2'd2, 1'b0, 32'h0, g_rd[0], g_rd[1], sp, b0, b1, w0, w1, rd);
        run_access(32'h2001, 2'd2, 1'b0, $urandom);
        total++; if (r_rdata !== rd) begin bad++; $display("FAIL gd_rdata got=%h exp=%h", r_rdata, rd); end
        total++; if (n_resp !== 1 || resp_c !== last_rv + 1) begin
            bad++; $display("FAIL gd_pulse got=n%0d cyc%0d exp=n1 cyc%0d", n_resp, resp_c, last_rv + 1); end
        total++; if (unstable !== 1'b0) begin bad++; $display("FAIL gd_hold got=%b exp=0", unstable); end
    endtask

    task automatic test_err_second();
        set_bus(0, 0, $urandom, $urandom, 1'b0, 1'b1);
        run_access(32'h3006, 2'd2, 1'b0, $urandom);
        total++; if ({r_err, r_split} !== 2'b11) begin
            bad++; $display("FAIL err2_flags got=err%b split%b exp=err1 split1", r_err, r_split); end
        total++; if (n_tx !== 2) begin bad++; $display("FAIL err2_ntx got=%0d exp=2", n_tx); end
    endtask

    task automatic test_reset_mid();
        logic seen;
        req_valid_i = 1'b1; req_addr_i = 32'h2002; req_size_i = 2'd2; req_we_i = 1'b0; req_wdata_i = 32'h0;
        @(negedge clk_i);
        req_valid_i = 1'b0; obi_gnt_i = 1'b1;
        @(negedge clk_i);
        obi_gnt_i = 1'b0;
        total++; if ({obi_req_o, obi_addr_o} !== {1'b1, 32'h2004}) begin
            bad++; $display("FAIL rm_addr2 got=%b/%h exp=1/00002004", obi_req_o, obi_addr_o); end
        obi_rvalid_i = 1'b1; obi_rdata_i = 32'hDEAD_BEEF; rst_ni = 1'b0;
        @(negedge clk_i);
        obi_rvalid_i = 1'b0; rst_ni = 1'b1;
        total++; if ({obi_req_o, req_ready_o, resp_valid_o, resp_split_o} !== 4'b0100) begin
            bad++; $display("FAIL rm_after got=%b exp=0100", {obi_req_o, req_ready_o, resp_valid_o, resp_split_o}); end
        @(negedge clk_i);
        obi_rvalid_i = 1'b1; obi_rdata_i = 32'hBAD0_BAD0;
        @(negedge clk_i);
        obi_rvalid_i = 1'b0; seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (resp_valid_o || obi_req_o || !req_ready_o) seen = 1'b1;
            @(negedge clk_i);
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL rm_stray got=%b exp=0", seen); end
        set_bus(0, 0, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b0);
        run_access(32'h3000, 2'd2, 1'b0, 32'h0);
        total++; if ({r_rdata, r_err, r_split} !== {32'hCAFE_F00D, 2'b00} || n_resp !== 1 || resp_c !== 3) begin
            bad++; $display("FAIL rm_next got=%h/%b/%b n%0d cyc%0d exp=cafef00d/0/0 n1 cyc3", r_rdata, r_err, r_split, n_resp, resp_c); end
    endtask

    task automatic test_random();
        logic sp; logic [3:0] b0, b1, eb; logic [31:0] w0, w1, rd, a, wd, ea, ew;
        logic [1:0] sz; logic we, ee; int ntx_exp;
        for (int it = 0; it < 40; it++) begin
            a  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3))) : $urandom;
            sz = 2'($urandom_range(0, 3)); we = 1'($urandom_range(0, 1)); wd = $urandom;
            for (int k = 0; k < 2; k++) begin
                g_gw[k] = $urandom_range(0, 2); g_rvd[k] = $urandom_range(0, 2);
                g_rd[k] = $urandom; g_er[k] = ($urandom_range(0, 3) == 0);
            end
            model(a, sz, we, wd, g_rd[0], g_rd[1], sp, b0, b1, w0, w1, rd);
            ntx_exp = sp ? 2 : 1;
            ee = g_er[0] | (sp & g_er[1]);
            run_access(a, sz, we, wd);
            total++; if (n_tx !== ntx_exp) begin bad++; $display("FAIL rnd_ntx it%0d got=%0d exp=%0d", it, n_tx, ntx_exp); end
            for (int k = 0; k < ntx_exp; k++) begin
                ea = (a & 32'hFFFF_FFFC) + 32'(4 * k);
                eb = (k == 0) ? b0 : b1;
                ew = (k == 0) ? w0 : w1;
                total++; if ({tx_addr[k], tx_be[k], tx_we[k]} !== {ea, eb, we} || (we && tx_wd[k] !== ew)) begin
                    bad++; $display("FAIL rnd_txn it%0d k%0d got=%h/%b/%b/%h exp=%h/%b/%b/%h",
                                    it, k, tx_addr[k], tx_be[k], tx_we[k], tx_wd[k], ea, eb, we, ew); end
            end
            total++; if ({r_rdata, r_err, r_split} !== {rd, ee, sp}) begin
                bad++; $display("FAIL rnd_resp it%0d got=%h/%b/%b exp=%h/%b/%b", it, r_rdata, r_err, r_split, rd, ee, sp); end
            total++; if (n_resp !== 1 || resp_c !== last_rv + 1 || unstable !== 1'b0) begin
                bad++; $display("FAIL rnd_pulse it%0d got=n%0d cyc%0d hold%b exp=n1 cyc%0d hold0", it, n_resp, resp_c, unstable, last_rv + 1); end
        end
    endtask

    initial begin
        req_valid_i = 1'b0; req_addr_i = 32'h0; req_we_i = 1'b0; req_size_i = 2'd0; req_wdata_i = 32'h0;
        obi_gnt_i = 1'b0; obi_rvalid_i = 1'b0; obi_rdata_i = 32'h0; obi_err_i = 1'b0;
        test_reset();
        test_aligned_load();
        test_split_store();
        test_split_load_half();
        test_gnt_delay();
        test_err_second();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
